// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Widest requester vector the helper below accepts.
    localparam int MAX_REQ = 8;

    // Convert a one-hot vector to the index of its set bit (0 when empty).
    function automatic int unsigned onehot2idx(input logic [MAX_REQ-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: finds the first asserted request
// searching upward from last_idx+1, wrapping modulo N_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int LW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [LW-1:0]    last_idx,
    output logic             found,
    output logic [N_REQ-1:0] pick_oh,
    output logic [LW-1:0]    pick_idx
);

    // cand[gi] is the requester examined at search position gi.
    logic [LW-1:0]    cand [N_REQ];
    logic [N_REQ-1:0] rot_req;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [LW:0] raw;
            assign raw         = {1'b0, last_idx} + (LW+1)'(gi + 1);
            assign cand[gi]    = (raw >= (LW+1)'(N_REQ)) ? LW'(raw - (LW+1)'(N_REQ)) : LW'(raw);
            assign rot_req[gi] = req[cand[gi]];
        end
    endgenerate

    // Priority scan over the rotated order; the first hit wins.
    always_comb begin
        found   = 1'b0;
        pick_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && rot_req[i]) begin
                found            = 1'b1;
                pick_oh[cand[i]] = 1'b1;
            end
        end
    end

    assign pick_idx = LW'(onehot2idx(MAX_REQ'(pick_oh)));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// Each grant covers a burst of up to MAX_BURST words; a full FIFO stalls the
// burst without releasing it, and a new burst starts only with enough room.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 32,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4,
    parameter int START_MIN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           grant,
    output logic                       busy,
    input  logic                       fifo_full_n,
    input  logic [$clog2(DEPTH)-1:0]   fifo_use_dw,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_data_in
);

    localparam int UW = $clog2(DEPTH);
    localparam int FW = UW + 1;
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int LW = $clog2(N_REQ);

    localparam logic [FW-1:0] DEPTH_W   = FW'(DEPTH);
    localparam logic [FW-1:0] START_W   = FW'(START_MIN);
    localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_BURST - 1);
    localparam logic [LW-1:0] LAST_INIT = LW'(N_REQ - 1);

    arb_state_t       state_reg, state_next;
    logic [N_REQ-1:0] grant_reg, grant_next;
    logic [LW-1:0]    gidx_reg, gidx_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [LW-1:0]    last_gnt_reg, last_gnt_next;

    logic [FW-1:0]    free;
    logic             pick_found;
    logic [N_REQ-1:0] pick_oh;
    logic [LW-1:0]    pick_idx;

    // Free words in the FIFO; a full FIFO reports no room regardless of use_dw.
    assign free = fifo_full_n ? (DEPTH_W - {1'b0, fifo_use_dw}) : '0;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req      (req_valid),
        .last_idx (last_gnt_reg),
        .found    (pick_found),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx)
    );

    // State, grant, burst counter and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            gidx_reg     <= '0;
            cnt_reg      <= '0;
            last_gnt_reg <= LAST_INIT;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            gidx_reg     <= gidx_next;
            cnt_reg      <= cnt_next;
            last_gnt_reg <= last_gnt_next;
        end
    end

    // Next-state: issue a grant from IDLE, count writes and end bursts in GRANT.
    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        gidx_next     = gidx_reg;
        cnt_next      = cnt_reg;
        last_gnt_next = last_gnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found && (free >= START_W)) begin
                    state_next = GRANT;
                    grant_next = pick_oh;
                    gidx_next  = pick_idx;
                    cnt_next   = '0;
                end
            end
            GRANT: begin
                if (!req_valid[gidx_reg]) begin
                    // Producer dropped out: release without writing.
                    state_next    = IDLE;
                    grant_next    = '0;
                    cnt_next      = '0;
                    last_gnt_next = gidx_reg;
                end else if (fifo_full_n) begin
                    if (cnt_reg == CNT_LAST) begin
                        state_next    = IDLE;
                        grant_next    = '0;
                        cnt_next      = '0;
                        last_gnt_next = gidx_reg;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                // Full FIFO: hold everything, the burst simply stalls.
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs: handshake, write strobe and data mux, all blocked during reset.
    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_data_in = '0;
        if (!rst && (state_reg == GRANT)) begin
            if (fifo_full_n) begin
                req_ready = grant_reg;
            end
            if (req_valid[gidx_reg] && fifo_full_n) begin
                fifo_wr_en   = 1'b1;
                fifo_data_in = req_data[gidx_reg*WIDTH +: WIDTH];
            end
        end
    end

    assign grant = grant_reg;
    assign busy  = (state_reg == GRANT);

endmodule
